// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers.
// Divider datapath compiled in only when MULDIV_UNIT_DIV_EN is defined.
module muldiv_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] srca,
   input  logic [31:0] srcb,
   input  logic        hiwrite,
   input  logic        lowrite,
   input  logic [31:0] wd,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt;
   logic [31:0] acc_hi, acc_lo, bmag;
   logic        neg_q;
   logic        accept, last;
   logic [31:0] step_hi, step_lo;
   logic [63:0] res;
   logic [32:0] sum;
   logic        sgn;
   logic [31:0] amag_in, bmag_in;
   logic        op_ok;

`ifdef MULDIV_UNIT_DIV_EN
   logic        is_div, neg_r, bz;
   logic [32:0] shf, dif;
   logic [31:0] qf, rf;
   assign op_ok = 1'b1;
`else
   assign op_ok = ~op[1];
`endif

   assign last = (state_q == RUN) && (cnt == 5'd31);
   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && op_ok) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN:     if (cnt == 5'd31) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operands are held as magnitudes; sign is restored on the last edge.
   assign sgn     = ~op[0];
   assign amag_in = (sgn && srca[31]) ? -srca : srca;
   assign bmag_in = (sgn && srcb[31]) ? -srcb : srcb;

   always_comb begin
      sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, bmag} : 33'd0);
      step_hi = sum[32:1];
      step_lo = {sum[0], acc_lo[31:1]};
      res     = {step_hi, step_lo};
      if (neg_q) res = -res;
`ifdef MULDIV_UNIT_DIV_EN
      shf = {acc_hi, acc_lo[31]};
      dif = shf - {1'b0, bmag};
      qf  = '0;
      rf  = '0;
      if (is_div) begin
         if (!dif[32]) begin
            step_hi = dif[31:0];
            step_lo = {acc_lo[30:0], 1'b1};
         end else begin
            step_hi = shf[31:0];
            step_lo = {acc_lo[30:0], 1'b0};
         end
         qf  = (neg_q && !bz) ? -step_lo : step_lo;
         rf  = neg_r ? -step_hi : step_hi;
         res = {rf, qf};
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         bmag   <= '0;
         neg_q  <= 1'b0;
`ifdef MULDIV_UNIT_DIV_EN
         is_div <= 1'b0;
         neg_r  <= 1'b0;
         bz     <= 1'b0;
`endif
      end else if (accept) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= amag_in;
         bmag   <= bmag_in;
         neg_q  <= sgn & (srca[31] ^ srcb[31]);
`ifdef MULDIV_UNIT_DIV_EN
         is_div <= op[1];
         neg_r  <= sgn & srca[31];
         bz     <= (srcb == 32'd0);
`endif
      end else if (state_q == RUN) begin
         cnt    <= cnt + 5'd1;
         acc_hi <= step_hi;
         acc_lo <= step_lo;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hi <= '0;
         lo <= '0;
      end else if (last) begin
         hi <= res[63:32];
         lo <= res[31:0];
      end else if (state_q != RUN) begin
         if (hiwrite) hi <= wd;
         if (lowrite) lo <= wd;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an
// arithmetic reference model; honours MULDIV_UNIT_DIV_EN.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] srca = '0, srcb = '0, wd = '0;
   logic        hiwrite = 1'b0, lowrite = 1'b0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int ncmp = 0;
   int nbad = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   muldiv_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .srca(srca), .srcb(srcb), .hiwrite(hiwrite),
      .lowrite(lowrite), .wd(wd), .hi(hi), .lo(lo),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         2'b00: p = sa * sb;
         2'b01: p = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic hw,
                         input logic [31:0] hwd);
      logic [63:0] e;
      @(negedge clk);
      start = 1'b1; op = o; srca = a; srcb = b;
      hiwrite = hw; wd = hwd;
      @(posedge clk); #1;
      start = 1'b0; hiwrite = 1'b0;
      if (hw) exp_hi = hwd;
`ifndef MULDIV_UNIT_DIV_EN
      if (o[1]) begin
         chk("nodiv_busy", {63'd0, busy}, 64'd0);
         chk("nodiv_done", {63'd0, done}, 64'd0);
         @(posedge clk); #1;
         chk("nodiv_busy2", {63'd0, busy}, 64'd0);
         chk("nodiv_hilo", {hi, lo}, {exp_hi, exp_lo});
         return;
      end
`endif
      chk("busy_c1", {63'd0, busy}, 64'd1);
      if (hw) chk("hi_mthi_start", {32'd0, hi}, {32'd0, hwd});
      for (int k = 2; k <= 32; k++) begin
         @(posedge clk); #1;
         chk("busy_run", {63'd0, busy}, 64'd1);
         chk("done_run", {63'd0, done}, 64'd0);
         if (k == 5) begin
            start = 1'b1; op = ~o; srca = $urandom; srcb = $urandom;
            lowrite = 1'b1; wd = 32'd0;
         end else begin
            start = 1'b0; lowrite = 1'b0;
         end
      end
      e = model(o, a, b);
      exp_hi = e[63:32];
      exp_lo = e[31:0];
      @(posedge clk); #1;
      chk("busy_done", {63'd0, busy}, 64'd0);
      chk("done_pulse", {63'd0, done}, 64'd1);
      chk($sformatf("result_op%0d", o), {hi, lo}, e);
      @(posedge clk); #1;
      chk("done_clear", {63'd0, done}, 64'd0);
      chk("busy_idle", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #1;
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      @(negedge clk); reset = 1'b1;

      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);
      chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
      run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b0, 0);
      chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
      run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, 0);
      run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 0);
      run_op(2'b11, 32'h00000005, 32'h00000000, 1'b0, 0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
      run_op(2'b10, 32'hFFFFFFF0, 32'h00000000, 1'b0, 0);
      run_op(2'b11, 32'hFFFFFFFF, 32'h00000010, 1'b0, 0);

      @(negedge clk); lowrite = 1'b1; wd = 32'h00001234;
      @(posedge clk); #1; lowrite = 1'b0;
      exp_lo = 32'h00001234;
      chk("mtlo_idle", {32'd0, lo}, {32'd0, exp_lo});
      @(negedge clk); hiwrite = 1'b1; wd = 32'hCAFEF00D;
      @(posedge clk); #1; hiwrite = 1'b0;
      exp_hi = 32'hCAFEF00D;
      chk("mthi_idle", {hi, lo}, {exp_hi, exp_lo});

      run_op(2'b01, 32'd12345, 32'd678, 1'b1, 32'hA5A5A5A5);

      @(negedge clk);
      start = 1'b1; op = 2'b01; srca = $urandom; srcb = $urandom;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      #1;
      exp_hi = 0; exp_lo = 0;
      chk("rst_run_hilo", {hi, lo}, 64'd0);
      chk("rst_run_busy", {63'd0, busy}, 64'd0);
      chk("rst_run_done", {63'd0, done}, 64'd0);
      @(negedge clk); reset = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         chk("no_done_after_rst", {63'd0, done}, 64'd0);
      end

      for (int n = 0; n < 40; n++) begin
         logic [1:0] o;
         logic [31:0] a, b;
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
         run_op(o, a, b, 1'b0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
